// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the countdown timer and its digit slices.
// Holds the digit width, the largest legal digit, the FSM states and a digit-valid helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  function automatic logic digit_valid(
    input logic [BCD_DIGIT_W-1:0] d
  );
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: decrement on borrow-in.
// Wraps 0 to 9 on a borrow and passes the borrow to the next digit up.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  input  logic                   borrow_in,
  output logic [BCD_DIGIT_W-1:0] digit_out,
  output logic                   borrow_out
);

  logic at_zero;

  assign at_zero    = (digit_in == '0);
  assign borrow_out = at_zero & borrow_in;

  always_comb begin
    digit_out = digit_in;
    if (borrow_in) begin
      if (at_zero) begin
        digit_out = BCD_MAX;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with pause/resume.
// Stops at zero or reloads the last preset, pulsing done on expiry.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic                          load,
  input  logic [DIGITS*BCD_DIGIT_W-1:0] load_value,
  input  logic                          start,
  input  logic                          pause,
  output logic [DIGITS*BCD_DIGIT_W-1:0] count,
  output logic                          running,
  output logic                          zero,
  output logic                          done,
  output logic                          load_err
);

  localparam int W = DIGITS * BCD_DIGIT_W;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] preset_q, preset_d;
  logic         done_q, done_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0]    dec_value;
  logic [DIGITS:0] borrow;
  logic            tick_en;
  logic            load_ok;
  logic            is_one;
  logic            is_zero;

  assign tick_en   = tick & (state_q == RUN)
                   & ~load & ~pause;
  assign borrow[0] = tick_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .digit_in   (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .borrow_in  (borrow[i]),
      .digit_out  (dec_value[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        load_ok = 1'b0;
      end
    end
  end

  assign is_zero = (count_q == '0);
  assign is_one  = (count_q == W'(1));

  // A borrow out of the top digit means count was 0: never wrap below zero.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    preset_d   = preset_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d  = load_value;
        preset_d = load_value;
        state_d  = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (start && state_q != RUN) begin
      if (!is_zero) begin
        state_d = RUN;
      end
    end else if (tick_en && !borrow[DIGITS]) begin
      if (is_one) begin
        done_d = 1'b1;
        if (AUTO_RELOAD != 0) begin
          count_d = preset_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else begin
        count_d = dec_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      preset_q   <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      preset_q   <= preset_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign running  = (state_q == RUN);
  assign zero     = is_zero;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: a stop-at-zero and an auto-reload instance
// checked every cycle against an integer model, plus directed literals.
module tb_bcd_down_timer;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic load = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic [15:0] load_value = 16'h0;

  logic [15:0] c0, c1;
  logic r0, r1, z0, z1, d0, d1, e0, e1;

  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(ND), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .load_value(load_value), .start(start), .pause(pause),
    .count(c0), .running(r0), .zero(z0), .done(d0),
    .load_err(e0)
  );

  bcd_down_timer #(.DIGITS(ND), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .load_value(load_value), .start(start), .pause(pause),
    .count(c1), .running(r1), .zero(z1), .done(d1),
    .load_err(e1)
  );

  // Model: value as a plain integer, state 0=idle 1=run 2=paused.
  typedef struct {
    int v;
    int pr;
    int st;
    bit dn;
    bit le;
  } model_t;

  model_t m0 = '{0, 0, 0, 1'b0, 1'b0};
  model_t m1 = '{0, 0, 0, 1'b0, 1'b0};

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < ND; i++)
      if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int r;
    r = 0;
    for (int i = ND - 1; i >= 0; i--)
      r = r * 10 + int'(b[i*4 +: 4]);
    return r;
  endfunction

  function automatic model_t step(
    input model_t m, input bit ar,
    input bit rn, input bit t, input bit l,
    input logic [15:0] lv, input bit s, input bit p
  );
    model_t n;
    n = m;
    n.dn = 1'b0;
    n.le = 1'b0;
    if (!rn) begin
      n.v = 0; n.pr = 0; n.st = 0;
    end else if (l) begin
      if (bcd_ok(lv)) begin
        n.v = from_bcd(lv); n.pr = n.v; n.st = 0;
      end else begin
        n.le = 1'b1;
      end
    end else if (p) begin
      if (m.st == 1) n.st = 2;
    end else if (s && m.st != 1) begin
      if (m.v != 0) n.st = 1;
    end else if (t && m.st == 1 && m.v > 0) begin
      if (m.v == 1) begin
        n.dn = 1'b1;
        if (ar) n.v = m.pr;
        else begin n.v = 0; n.st = 0; end
      end else begin
        n.v = m.v - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, 1'b0, rst_n, tick, load, load_value, start, pause);
    m1 <= step(m1, 1'b1, rst_n, tick, load, load_value, start, pause);
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (d0) done_cnt0 <= done_cnt0 + 1;
    if (chk_en) begin
      check("m0.count", c0, to_bcd(m0.v));
      check("m0.running", 16'(r0), 16'(m0.st == 1));
      check("m0.zero", 16'(z0), 16'(m0.v == 0));
      check("m0.done", 16'(d0), 16'(m0.dn));
      check("m0.load_err", 16'(e0), 16'(m0.le));
      check("m1.count", c1, to_bcd(m1.v));
      check("m1.running", 16'(r1), 16'(m1.st == 1));
      check("m1.zero", 16'(z1), 16'(m1.v == 0));
      check("m1.done", 16'(d1), 16'(m1.dn));
      check("m1.load_err", 16'(e1), 16'(m1.le));
    end
  end

  task automatic drv(input bit t, input bit l, input logic [15:0] lv,
                     input bit s, input bit p);
    tick = t; load = l; load_value = lv; start = s; pause = p;
    @(negedge clk);
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 16'h0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drv(1, 0, 16'h0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  int snap;

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    check("reset count", c0, 16'h0000);
    check("reset zero", 16'(z0), 16'h1);
    check("reset running", 16'(r0), 16'h0);
    check("reset done", 16'(d0), 16'h0);

    // Long countdown across digit borrows
    drv(0, 1, 16'h0102, 0, 0);
    check("t1 load", c0, 16'h0102);
    drv(0, 0, 16'h0, 1, 0);
    check("t1 start", 16'(r0), 16'h1);
    ticks(1);
    check("t1 0101", c0, 16'h0101);
    ticks(2);
    check("t1 0099", c0, 16'h0099);
    ticks(99);
    check("t1 end count", c0, 16'h0000);
    check("t1 done pulse", 16'(d0), 16'h1);
    check("t1 running", 16'(r0), 16'h0);
    ticks(1);
    check("t1 done one cycle", 16'(d0), 16'h0);
    ticks(3);
    check("t1 hold zero", c0, 16'h0000);

    // Invalid load, start at zero
    drv(0, 1, 16'h00A5, 0, 0);
    check("t2 load_err", 16'(e0), 16'h1);
    check("t2 count kept", c0, 16'h0000);
    idle(1);
    check("t2 load_err clear", 16'(e0), 16'h0);
    drv(0, 0, 16'h0, 1, 0);
    check("t2 start at zero", 16'(r0), 16'h0);

    // Pause / resume
    drv(0, 1, 16'h0010, 0, 0);
    drv(0, 0, 16'h0, 1, 0);
    ticks(3);
    check("t3 0007", c0, 16'h0007);
    drv(0, 0, 16'h0, 0, 1);
    ticks(5);
    check("t3 paused hold", c0, 16'h0007);
    check("t3 paused running", 16'(r0), 16'h0);
    drv(0, 0, 16'h0, 1, 0);
    ticks(1);
    check("t3 0006", c0, 16'h0006);
    drv(0, 0, 16'h0, 1, 1);
    check("t3 pause wins", 16'(r0), 16'h0);
    check("t3 pause count", c0, 16'h0006);

    // Load during RUN beats same-cycle tick
    drv(0, 1, 16'h0456, 0, 0);
    drv(0, 0, 16'h0, 1, 0);
    drv(1, 1, 16'h0200, 0, 0);
    check("t4 load over tick", c0, 16'h0200);
    check("t4 idle", 16'(r0), 16'h0);

    // Borrow through three zero digits
    drv(0, 1, 16'h1000, 0, 0);
    drv(0, 0, 16'h0, 1, 0);
    ticks(1);
    check("t4 1000->0999", c0, 16'h0999);

    // Reset mid-run
    drv(0, 1, 16'h0003, 0, 0);
    drv(0, 0, 16'h0, 1, 0);
    snap = done_cnt0;
    tick = 1'b1;
    do_reset();
    check("t5 count", c0, 16'h0000);
    check("t5 zero", 16'(z0), 16'h1);
    check("t5 running", 16'(r0), 16'h0);
    idle(3);
    check("t5 no done", 16'(done_cnt0), 16'(snap));

    // Auto-reload instance
    drv(0, 1, 16'h0003, 0, 0);
    drv(0, 0, 16'h0, 1, 0);
    ticks(1);
    check("t6 0002", c1, 16'h0002);
    ticks(1);
    check("t6 0001", c1, 16'h0001);
    ticks(1);
    check("t6 reload", c1, 16'h0003);
    check("t6 done", 16'(d1), 16'h1);
    check("t6 running", 16'(r1), 16'h1);
    ticks(1);
    check("t6 0002 again", c1, 16'h0002);
    check("t6 done clear", 16'(d1), 16'h0);
    check("t6 still running", 16'(r1), 16'h1);

    // Back-to-back expiries with preset 1
    drv(0, 1, 16'h0001, 0, 0);
    drv(0, 0, 16'h0, 1, 0);
    ticks(1);
    check("t6 p1 done a", 16'(d1), 16'h1);
    check("t6 p1 count", c1, 16'h0001);
    ticks(1);
    check("t6 p1 done b", 16'(d1), 16'h1);
    idle(1);
    check("t6 p1 done off", 16'(d1), 16'h0);
    check("t6 p1 zero", 16'(z1), 16'h0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
